rom_voice_scheduler: RTL and testbench
======================================

// Module: rom_voice_scheduler
// PURPOSE
//  Time-shares one 512x16 sine ROM (sync read, 1-cycle latency) among NUM_VOICES
//  phase-accumulator oscillators. Each sample_tick runs one frame: every voice issues
//  one ROM read, captures its sample and advances its phase; a signed mix is emitted.
//  Sits between step-sequencer pitch control (voice_en, phase_inc) and the audio output path.
// PARAMETERS
//  NUM_VOICES  4   voices sharing the ROM (>=1)
//  PHASE_W     24  phase accumulator width; ROM address = phase[PHASE_W-1 -: ADDR_W]
//  ADDR_W      9   ROM address width
//  DATA_W      16  ROM word width, signed two's complement
//  MIX_W       DATA_W+$clog2(NUM_VOICES) (18)  mix_out width, no overflow possible
// PORTS
//  clock         in   1                   system clock, all logic on posedge
//  resetn        in   1                   async active-low reset
//  sample_tick   in   1                   one-cycle frame start request
//  voice_en      in   NUM_VOICES          per-voice enable
//  phase_inc     in   NUM_VOICES*PHASE_W  per-voice increment, voice i at [i*PHASE_W +: PHASE_W]
//  rom_address   out  ADDR_W              registered address to ROM
//  rom_q         in   DATA_W              ROM read data
//  voice_sample  out  NUM_VOICES*DATA_W   last captured sample per voice
//  mix_out       out  MIX_W               signed sum of frame samples
//  mix_valid     out  1                   one-cycle pulse, mix_out updated
//  busy          out  1                   frame in progress
//  overrun       out  1                   one-cycle pulse, tick dropped
// BEHAVIOUR
//  Reset (async, resetn=0): all phases, rom_address, voice_sample, mix_out, accumulator = 0;
//   mix_valid, busy, overrun = 0; FSM -> IDLE. Reset mid-frame aborts; no mix_valid issued.
//  FSM IDLE -> RUN on tick while IDLE; RUN -> IDLE after last capture. Edges E0..E(N+1), N=NUM_VOICES.
//  Issue: at edge Ei (i=0..N-1; E0 = tick-accept edge) for voice i:
//   rom_address <= phase[i][MSBs]; phase[i] <= phase[i]+phase_inc[i] (mod 2^PHASE_W);
//   voice_en[i] and phase_inc[i] sampled at Ei only; enable flag pipelined with the read.
//  Disabled voice at its issue edge: phase[i] <= 0, address issued = 0, captured sample forced 0.
//  Capture: at edge E(i+2) voice_sample[i] <= rom_q (or 0); accumulator += sign-extended sample.
//   Issue and capture overlap (E2..E(N-1) do both).
//  At E(N+1): mix_out <= final sum; mix_valid=1 for the following cycle only; busy<=0;
//   accumulator cleared. busy=1 in cycles after E0 through E(N+1). Frame = N+2 cycles.
//  Tick sampled while busy=1 (incl. the E(N+1) edge): dropped, overrun=1 for one cycle, frame unaffected.
//  rom_address holds its last value when idle. Ticks never queue.
// TESTING (ROM model: synchronous, mem[a]=a sign-extended unless noted)
//  1 resetn=0 with random inputs -> every output 0; release, no tick -> outputs stay 0, busy=0.
//  2 N=4, only voice0 en, inc=0x008000 -> rom_address 0,1,2.. in consecutive frames;
//    mix_out=0,1,2..; mix_valid 6 cycles after tick edge; voice_sample[1..3]=0.
//  3 all en, inc={0x008000,0x010000,0x018000,0x020000}, 2nd frame -> addresses 1,2,3,4 on
//    E0..E3; mix_out=10; voice_sample={4,3,2,1}.
//  4 voice0 inc=0x800000 -> addresses alternate 0,256; phase 0xFF8000+0x8000 wraps to 0.
//    ROM mem[a]=0x8000 -> mix_out with all 4 en = -131072 (0x20000), no overflow.
//  5 tick 3 cycles into frame -> overrun pulse 1 cycle, mix_out unchanged; tick after busy=0
//    accepted. Drop voice_en[2] mid-run -> voice 2 contributes 0 next frame, phase[2]=0.
//  6 resetn low at cycle 3 of frame -> immediate reset values, no mix_valid; next tick restarts at phase 0.

Source files
------------

// File: rtl/rom_voice_scheduler.sv
// rom_voice_scheduler: time-shares one synchronous sine ROM among NUM_VOICES
// phase-accumulator voices; each accepted sample_tick runs one frame and emits a signed mix.
module rom_voice_scheduler #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned PHASE_W    = 24,
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MIX_W      = DATA_W + $clog2(NUM_VOICES)
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          sample_tick,
    input  logic [NUM_VOICES-1:0]         voice_en,
    input  logic [NUM_VOICES*PHASE_W-1:0] phase_inc,
    output logic [ADDR_W-1:0]             rom_address,
    input  logic [DATA_W-1:0]             rom_q,
    output logic [NUM_VOICES*DATA_W-1:0]  voice_sample,
    output logic [MIX_W-1:0]              mix_out,
    output logic                          mix_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int unsigned      CNT_W     = $clog2(NUM_VOICES + 2);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(NUM_VOICES + 1);
    localparam logic [CNT_W-1:0] NUM_V_C   = CNT_W'(NUM_VOICES);
    localparam logic [CNT_W-1:0] CAP_LAG   = CNT_W'(2);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      edge_q, edge_d;
    logic [PHASE_W-1:0]    phase_q  [NUM_VOICES];
    logic [PHASE_W-1:0]    phase_d  [NUM_VOICES];
    logic [DATA_W-1:0]     sample_q [NUM_VOICES];
    logic [DATA_W-1:0]     sample_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_q, en_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [MIX_W-1:0]      acc_q, acc_d;
    logic [MIX_W-1:0]      mix_q, mix_d;
    logic                  mix_valid_q, mix_valid_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;

    logic                  issue_vld;
    logic                  cap_vld;
    logic                  last_edge;
    logic [CNT_W-1:0]      issue_idx;
    logic [CNT_W-1:0]      cap_idx;
    logic [DATA_W-1:0]     cap_val;
    logic [MIX_W-1:0]      acc_sum;

    // edge_q holds k while the upcoming edge is Ek; E0 is handled from IDLE.
    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        busy_d    = busy_q;
        overrun_d = sample_tick && busy_q;
        issue_vld = 1'b0;
        issue_idx = '0;
        cap_vld   = 1'b0;
        cap_idx   = '0;
        last_edge = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    state_d   = S_RUN;
                    edge_d    = CNT_W'(1);
                    busy_d    = 1'b1;
                    issue_vld = 1'b1;
                end
            end
            S_RUN: begin
                edge_d = edge_q + 1'b1;
                if (edge_q < NUM_V_C) begin
                    issue_vld = 1'b1;
                    issue_idx = edge_q;
                end
                if (edge_q >= CAP_LAG) begin
                    cap_vld = 1'b1;
                    cap_idx = edge_q - CAP_LAG;
                end
                if (edge_q == LAST_EDGE) begin
                    state_d   = S_IDLE;
                    edge_d    = '0;
                    busy_d    = 1'b0;
                    last_edge = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        en_d        = en_q;
        acc_d       = acc_q;
        mix_d       = mix_q;
        mix_valid_d = 1'b0;
        cap_val     = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            phase_d[i]  = phase_q[i];
            sample_d[i] = sample_q[i];
        end
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (issue_vld && issue_idx == CNT_W'(i)) begin
                en_d[i] = voice_en[i];
                if (voice_en[i]) begin
                    addr_d     = phase_q[i][PHASE_W-1 -: ADDR_W];
                    phase_d[i] = phase_q[i] + phase_inc[i*PHASE_W +: PHASE_W];
                end else begin
                    addr_d     = '0;
                    phase_d[i] = '0;
                end
            end
            // The enable flag captured at issue gates the ROM word two edges later.
            if (cap_vld && cap_idx == CNT_W'(i)) begin
                sample_d[i] = en_q[i] ? rom_q : '0;
                cap_val     = sample_d[i];
            end
        end
        acc_sum = acc_q + MIX_W'($signed(cap_val));
        if (cap_vld) begin
            acc_d = acc_sum;
        end
        if (last_edge) begin
            mix_d       = acc_sum;
            acc_d       = '0;
            mix_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            edge_q      <= '0;
            en_q        <= '0;
            addr_q      <= '0;
            acc_q       <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                phase_q[i]  <= '0;
                sample_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            edge_q      <= edge_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            acc_q       <= acc_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                phase_q[i]  <= phase_d[i];
                sample_q[i] <= sample_d[i];
            end
        end
    end

    always_comb begin
        voice_sample = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            voice_sample[i*DATA_W +: DATA_W] = sample_q[i];
        end
    end

    assign rom_address = addr_q;
    assign mix_out     = mix_q;
    assign mix_valid   = mix_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_rom_voice_scheduler.sv
// Scoreboard bench for rom_voice_scheduler: a per-frame reference model pushes
// expected frames and overrun pulses; a monitor pops and compares DUT outputs.
module tb_rom_voice_scheduler;

    localparam int unsigned NV = 4;
    localparam int unsigned PW = 24;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;
    localparam int unsigned MW = 18;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              sample_tick = 1'b0;
    logic [NV-1:0]     voice_en = '0;
    logic [NV*PW-1:0]  phase_inc = '0;
    logic [AW-1:0]     rom_address;
    logic [DW-1:0]     rom_q = '0;
    logic [NV*DW-1:0]  voice_sample;
    logic [MW-1:0]     mix_out;
    logic              mix_valid;
    logic              busy;
    logic              overrun;

    rom_voice_scheduler #(
        .NUM_VOICES(NV),
        .PHASE_W   (PW),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MIX_W     (MW)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .sample_tick (sample_tick),
        .voice_en    (voice_en),
        .phase_inc   (phase_inc),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .voice_sample(voice_sample),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem [512];
    always @(posedge clock) rom_q <= mem[rom_address];

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [NV-1:0][AW-1:0] addrs;
        logic [NV-1:0][DW-1:0] smp;
        logic [MW-1:0]         mix;
        int unsigned           done_cyc;
    } frame_t;

    frame_t        exp_q[$];
    int unsigned   ovr_q[$];
    logic [PW-1:0] m_phase [NV];
    int unsigned   frame_start = 1;
    int unsigned   frame_end = 0;
    logic [MW-1:0] last_mix = '0;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void mem_ramp();
        logic [AW-1:0] a;
        for (int unsigned k = 0; k < 512; k++) begin
            a = AW'(k);
            mem[k] = {{(DW-AW){a[AW-1]}}, a};
        end
    endfunction

    // One whole frame from the sampled controls: each voice reads the ROM at the
    // top bits of its phase, then advances (or clears when disabled).
    function automatic frame_t model_frame(input int unsigned e0);
        frame_t f;
        longint signed sum = 0;
        for (int unsigned i = 0; i < NV; i++) begin
            if (voice_en[i]) begin
                f.addrs[i] = m_phase[i][PW-1 -: AW];
                f.smp[i]   = mem[f.addrs[i]];
                m_phase[i] = m_phase[i] + phase_inc[i*PW +: PW];
            end else begin
                f.addrs[i] = '0;
                f.smp[i]   = '0;
                m_phase[i] = '0;
            end
            sum += longint'($signed(f.smp[i]));
        end
        f.mix      = MW'(sum);
        f.done_cyc = e0 + NV + 1;
        return f;
    endfunction

    // Drives one cycle from a negedge and ends on the next negedge.
    task automatic step(input logic tick);
        int unsigned e;
        e = cyc + 1;
        sample_tick = tick;
        if (tick) begin
            if (e > frame_end) begin
                exp_q.push_back(model_frame(e));
                frame_start = e;
                frame_end   = e + NV + 1;
            end else begin
                ovr_q.push_back(e);
            end
        end
        @(negedge clock);
        sample_tick = 1'b0;
    endtask

    task automatic run_frame();
        step(1'b1);
        repeat (NV + 2) step(1'b0);
    endtask

    task automatic do_reset(input int unsigned hold);
        resetn = 1'b0;
        sample_tick = 1'b0;
        exp_q.delete();
        ovr_q.delete();
        for (int unsigned i = 0; i < NV; i++) m_phase[i] = '0;
        frame_end = cyc;
        last_mix  = '0;
        repeat (hold) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    function automatic logic idle_next();
        return (cyc + 1) > frame_end;
    endfunction

    // Monitor: samples just after each active edge.
    logic [AW-1:0] seen_addr [NV];
    int unsigned   fpos = 0;
    initial begin
        frame_t f;
        forever begin
            @(posedge clock);
            #1;
            check("busy", 64'(busy), 64'((cyc >= frame_start) && (cyc < frame_end)));
            if (!busy) fpos = 0;
            else if (fpos < NV) begin
                seen_addr[fpos] = rom_address;
                fpos++;
            end
            if (mix_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_mix_valid", 64'(mix_valid), 64'(0));
                end else begin
                    f = exp_q.pop_front();
                    check("mix_latency", 64'(cyc), 64'(f.done_cyc));
                    check("mix_out", 64'(mix_out), 64'(f.mix));
                    for (int unsigned i = 0; i < NV; i++) begin
                        check($sformatf("rom_address_v%0d", i), 64'(seen_addr[i]), 64'(f.addrs[i]));
                        check($sformatf("voice_sample_v%0d", i), 64'(voice_sample[i*DW +: DW]), 64'(f.smp[i]));
                    end
                    last_mix = f.mix;
                end
            end
            if (overrun) begin
                if (ovr_q.size() == 0) check("unexpected_overrun", 64'(overrun), 64'(0));
                else begin
                    check("overrun_cycle", 64'(cyc), 64'(ovr_q.pop_front()));
                    check("mix_hold_on_overrun", 64'(mix_out), 64'(last_mix));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_address"}, 64'(rom_address), 64'(0));
        check({tag, "_voice_sample"}, 64'(voice_sample), 64'(0));
        check({tag, "_mix_out"}, 64'(mix_out), 64'(0));
        check({tag, "_mix_valid"}, 64'(mix_valid), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_overrun"}, 64'(overrun), 64'(0));
    endtask

    initial begin
        mem_ramp();
        for (int unsigned i = 0; i < NV; i++) m_phase[i] = '0;

        // Held in reset with random inputs, then idle without ticks.
        repeat (2) @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            voice_en    = NV'($urandom);
            phase_inc   = {$urandom, $urandom, $urandom};
            sample_tick = 1'($urandom);
            @(negedge clock);
            #1;
            check_all_zero("in_reset");
        end
        sample_tick = 1'b0;
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            voice_en  = NV'($urandom);
            phase_inc = {$urandom, $urandom, $urandom};
            @(negedge clock);
            #1;
            check_all_zero("idle");
        end
        @(negedge clock);

        // Single voice stepping one ROM word per frame.
        do_reset(2);
        voice_en  = 4'b0001;
        phase_inc = {24'h0, 24'h0, 24'h0, 24'h008000};
        repeat (5) run_frame();

        // All voices with distinct increments.
        do_reset(2);
        voice_en  = 4'b1111;
        phase_inc = {24'h020000, 24'h018000, 24'h010000, 24'h008000};
        repeat (3) run_frame();

        // Half-cycle increment and phase wrap.
        do_reset(2);
        voice_en  = 4'b0001;
        phase_inc = {24'h0, 24'h0, 24'h0, 24'h800000};
        repeat (3) run_frame();
        phase_inc = {24'h0, 24'h0, 24'h0, 24'h7FC000};
        repeat (4) run_frame();

        // Most-negative word on every voice: full-scale negative mix.
        for (int unsigned k = 0; k < 512; k++) mem[k] = 16'h8000;
        voice_en  = 4'b1111;
        phase_inc = {$urandom, $urandom, $urandom};
        repeat (2) run_frame();
        mem_ramp();

        // Ticks mid-frame and on the final edge are dropped; next one accepted.
        do_reset(2);
        voice_en  = 4'b1111;
        phase_inc = {24'h020000, 24'h018000, 24'h010000, 24'h008000};
        step(1'b1);
        repeat (2) step(1'b0);
        step(1'b1);
        repeat (NV) step(1'b0);
        step(1'b1);
        repeat (NV + 1) step(1'b0);
        step(1'b1);
        repeat (NV + 2) step(1'b0);
        voice_en = 4'b1011;
        repeat (2) run_frame();
        voice_en = 4'b1111;
        repeat (2) run_frame();

        // Reset three cycles into a frame aborts it; the next frame restarts at phase 0.
        step(1'b1);
        repeat (2) step(1'b0);
        do_reset(2);
        repeat (2) run_frame();

        // Randomised traffic: controls and ROM contents change only between frames.
        do_reset(2);
        for (int k = 0; k < 1500; k++) begin
            if (idle_next()) begin
                if ($urandom_range(0, 3) == 0) begin
                    voice_en = NV'($urandom);
                    for (int unsigned i = 0; i < NV; i++)
                        phase_inc[i*PW +: PW] = ($urandom_range(0, 1) == 0) ? PW'($urandom) : PW'($urandom_range(0, 32'h40000));
                end
                if ($urandom_range(0, 60) == 0) begin
                    for (int unsigned a = 0; a < 512; a++) mem[a] = DW'($urandom);
                end
                if ($urandom_range(0, 400) == 0) do_reset(1);
            end
            step($urandom_range(0, 2) == 0);
        end

        for (int k = 0; k < 20 && (exp_q.size() != 0 || ovr_q.size() != 0); k++) @(negedge clock);
        check("drain_frames", 64'(exp_q.size()), 64'(0));
        check("drain_overruns", 64'(ovr_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
